// File: rtl/clock_display_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_display_scan_if
//  Brief    : Time/edit-field inputs and 7-segment scan outputs between the
//             digital-clock core and its display stage.
//  Revision : 1.0  initial release
// ============================================================================
interface clock_display_scan_if;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [1:0] edit_field;
   logic [7:0] an;
   logic [7:0] seg;

   // Clock core side: provides the time, observes the display drive
   modport master (
      output hours, minutes, seconds, edit_field,
      input  an, seg
   );

   // Display stage side
   modport slave (
      input  hours, minutes, seconds, edit_field,
      output an, seg
   );
endinterface
`default_nettype wire

// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : clock_display_scan
//  Brief    : Scans HH-MM-SS onto an 8-digit multiplexed 7-segment display.
//             Inputs are snapshotted once per frame so a frame is always
//             self-consistent; the field under edit blinks.
//  Revision : 1.0  initial release
// ============================================================================
module clock_display_scan #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  wire logic             clock,
   input  wire logic             reset,
   clock_display_scan_if.slave   disp
);

   localparam int c_SCAN_W  = $clog2(SCAN_DIV);
   localparam int c_BLINK_W = $clog2(BLINK_DIV);
   localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
   localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
   localparam logic [7:0] c_SEG_DASH  = 8'hBF;
   localparam logic [7:0] c_SEG_BLANK = 8'hFF;

   // Active-low segment pattern for one decimal digit, dp held off
   function automatic logic [7:0] f_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Values up to 63 give a tens digit of at most 6, so 4 bits suffice
   function automatic logic [3:0] f_tens(input logic [5:0] v);
      return 4'(v / 6'd10);
   endfunction

   function automatic logic [3:0] f_units(input logic [5:0] v);
      return 4'(v % 6'd10);
   endfunction

   logic [c_SCAN_W-1:0]  r_scan_cnt;
   logic [2:0]           r_digit_idx;
   logic [c_BLINK_W-1:0] r_blink_cnt;
   logic                 r_blink_on;
   logic                 r_armed;
   logic [4:0]           r_snap_h;
   logic [5:0]           r_snap_m;
   logic [5:0]           r_snap_s;
   logic [1:0]           r_edit_q;
   logic [7:0]           r_an;
   logic [7:0]           r_seg;

   logic                 w_scan_tc;
   logic [c_SCAN_W-1:0]  w_scan_nxt;
   logic [2:0]           w_digit_nxt;
   logic                 w_load;
   logic [4:0]           w_snap_h_nxt;
   logic [5:0]           w_snap_m_nxt;
   logic [5:0]           w_snap_s_nxt;
   logic                 w_edit_chg;
   logic                 w_blink_tc;
   logic [c_BLINK_W-1:0] w_blink_cnt_nxt;
   logic                 w_blink_on_nxt;
   logic [1:0]           w_digit_field;
   logic [7:0]           w_digit_seg;
   logic                 w_blank;
   logic [7:0]           w_an_nxt;
   logic [7:0]           w_seg_nxt;

   // Next-state timing, snapshot, blink and the segment/anode pattern that
   // the outputs will carry once the edge has been taken
   always_comb begin
      w_scan_tc    = (r_scan_cnt == c_SCAN_LAST);
      w_scan_nxt   = w_scan_tc ? '0 : r_scan_cnt + c_SCAN_W'(1);
      w_digit_nxt  = w_scan_tc ? r_digit_idx + 3'd1 : r_digit_idx;

      // Fresh values only at a frame boundary or on the first edge out of reset
      w_load       = !r_armed || (w_scan_tc && (r_digit_idx == 3'd7));
      w_snap_h_nxt = w_load ? disp.hours   : r_snap_h;
      w_snap_m_nxt = w_load ? disp.minutes : r_snap_m;
      w_snap_s_nxt = w_load ? disp.seconds : r_snap_s;

      // A new edit selection restarts the blink in its visible phase,
      // overriding a terminal count on the same edge
      w_edit_chg   = (disp.edit_field != r_edit_q);
      w_blink_tc   = (r_blink_cnt == c_BLINK_LAST);
      if (w_edit_chg) begin
         w_blink_cnt_nxt = '0;
         w_blink_on_nxt  = 1'b1;
      end else if (w_blink_tc) begin
         w_blink_cnt_nxt = '0;
         w_blink_on_nxt  = ~r_blink_on;
      end else begin
         w_blink_cnt_nxt = r_blink_cnt + c_BLINK_W'(1);
         w_blink_on_nxt  = r_blink_on;
      end

      // Field code matches edit_field encoding: 1 hours, 2 minutes, 3 seconds,
      // 0 marks a dash position that never blanks
      w_digit_field = 2'd0;
      w_digit_seg   = c_SEG_DASH;
      case (w_digit_nxt)
         3'd7: begin w_digit_field = 2'd1; w_digit_seg = f_seg(f_tens({1'b0, w_snap_h_nxt}));  end
         3'd6: begin w_digit_field = 2'd1; w_digit_seg = f_seg(f_units({1'b0, w_snap_h_nxt})); end
         3'd4: begin w_digit_field = 2'd2; w_digit_seg = f_seg(f_tens(w_snap_m_nxt));          end
         3'd3: begin w_digit_field = 2'd2; w_digit_seg = f_seg(f_units(w_snap_m_nxt));         end
         3'd1: begin w_digit_field = 2'd3; w_digit_seg = f_seg(f_tens(w_snap_s_nxt));          end
         3'd0: begin w_digit_field = 2'd3; w_digit_seg = f_seg(f_units(w_snap_s_nxt));         end
         default: begin w_digit_field = 2'd0; w_digit_seg = c_SEG_DASH; end
      endcase

      w_blank   = (disp.edit_field != 2'd0) && !w_blink_on_nxt &&
                  (w_digit_field == disp.edit_field);
      w_seg_nxt = w_blank ? c_SEG_BLANK : w_digit_seg;
      w_an_nxt  = ~(8'd1 << w_digit_nxt);
   end

   // State and registered display drive; reset aborts any frame in progress
   always_ff @(posedge clock) begin
      if (reset) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= 3'd0;
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
         r_armed     <= 1'b0;
         r_snap_h    <= 5'd0;
         r_snap_m    <= 6'd0;
         r_snap_s    <= 6'd0;
         r_edit_q    <= 2'd0;
         r_an        <= 8'hFF;
         r_seg       <= 8'hFF;
      end else begin
         r_scan_cnt  <= w_scan_nxt;
         r_digit_idx <= w_digit_nxt;
         r_blink_cnt <= w_blink_cnt_nxt;
         r_blink_on  <= w_blink_on_nxt;
         r_armed     <= 1'b1;
         r_snap_h    <= w_snap_h_nxt;
         r_snap_m    <= w_snap_m_nxt;
         r_snap_s    <= w_snap_s_nxt;
         r_edit_q    <= disp.edit_field;
         r_an        <= w_an_nxt;
         r_seg       <= w_seg_nxt;
      end
   end

   assign disp.an  = r_an;
   assign disp.seg = r_seg;

endmodule
`default_nettype wire
